// File: rtl/watch_setter_pkg.sv
// Shared types and constants for the watch time-setting controller.
// Holds the FSM state encoding, edit_field codes, bin_watch slice positions and wrap helpers.
package watch_setter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_HOUR,
    ST_SET_MIN,
    ST_SET_SEC,
    ST_COMMIT
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam int BIN_W    = 17;
  localparam int HOUR_MSB = 16;
  localparam int HOUR_LSB = 12;
  localparam int MIN_MSB  = 11;
  localparam int MIN_LSB  = 6;
  localparam int SEC_MSB  = 5;
  localparam int SEC_LSB  = 0;

  // Compare-based wrap: anything at or above max (including out-of-range loads) becomes 0.
  function automatic logic [4:0] inc_wrap5(input logic [4:0] val, input logic [4:0] max);
    return (val >= max) ? 5'd0 : val + 5'd1;
  endfunction

  function automatic logic [5:0] inc_wrap6(input logic [5:0] val, input logic [5:0] max);
    return (val >= max) ? 6'd0 : val + 6'd1;
  endfunction

endpackage

// File: rtl/watch_setter_btn_edge.sv
// Registered rising-edge detector for one debounced button level.
// The detector stays disarmed after reset until the button has been seen low.
module btn_edge
  import watch_setter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_rise
);

  logic r_prev;
  logic r_armed;
  logic r_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_prev  <= i_btn;
      r_armed <= r_armed | ~i_btn;
      r_rise  <= i_btn & ~r_prev & r_armed;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/watch_setter.sv
// Time-setting controller: captures the running time, lets the user step through
// hour/minute/second with mode/up buttons, and emits a one-cycle load strobe on commit.
module watch_setter
  import watch_setter_pkg::*;
#(
  parameter int HOUR_MAX   = 23,
  parameter int MINSEC_MAX = 59
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_1hz,
  input  logic             btn_mode,
  input  logic             btn_up,
  input  logic             btn_cancel,
  input  logic [4:0]       hour,
  input  logic [5:0]       minute,
  input  logic [5:0]       second,
  output logic [BIN_W-1:0] bin_watch,
  output logic             set_watch,
  output logic [1:0]       edit_field,
  output logic             blink
);

  localparam logic [4:0] LP_HMAX = 5'(HOUR_MAX);
  localparam logic [5:0] LP_MMAX = 6'(MINSEC_MAX);

  logic [2:0] w_btn;
  logic [2:0] w_evt;
  logic       w_mode;
  logic       w_up;
  logic       w_cancel;
  logic [4:0] w_hour_inc;
  logic [5:0] w_min_inc;
  logic [5:0] w_sec_inc;

  state_t           r_state;
  logic [BIN_W-1:0] r_bin;
  logic             r_set;
  logic [1:0]       r_field;
  logic             r_blink;

  assign w_btn = {btn_cancel, btn_up, btn_mode};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
      btn_edge u_edge (
        .clk   (clk),
        .rst   (rst),
        .i_btn (w_btn[gi]),
        .o_rise(w_evt[gi])
      );
    end
  endgenerate

  assign w_mode   = w_evt[0];
  assign w_up     = w_evt[1];
  assign w_cancel = w_evt[2];

  assign w_hour_inc = inc_wrap5(r_bin[HOUR_MSB:HOUR_LSB], LP_HMAX);
  assign w_min_inc  = inc_wrap6(r_bin[MIN_MSB:MIN_LSB], LP_MMAX);
  assign w_sec_inc  = inc_wrap6(r_bin[SEC_MSB:SEC_LSB], LP_MMAX);

  // Priority within a SET_* state: cancel, then mode, then up, then the blink tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_set   <= 1'b0;
      r_field <= FIELD_NONE;
      r_blink <= 1'b0;
    end else begin
      r_set <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_field <= FIELD_NONE;
          r_blink <= 1'b0;
          if (w_mode) begin
            r_bin   <= {hour, minute, second};
            r_state <= ST_SET_HOUR;
            r_field <= FIELD_HOUR;
          end
        end
        ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
          if (w_cancel) begin
            r_state <= ST_IDLE;
            r_field <= FIELD_NONE;
            r_blink <= 1'b0;
          end else if (w_mode) begin
            r_blink <= 1'b0;
            if (r_state == ST_SET_HOUR) begin
              r_state <= ST_SET_MIN;
              r_field <= FIELD_MIN;
            end else if (r_state == ST_SET_MIN) begin
              r_state <= ST_SET_SEC;
              r_field <= FIELD_SEC;
            end else begin
              r_state <= ST_COMMIT;
              r_field <= FIELD_NONE;
              r_set   <= 1'b1;
            end
          end else if (w_up) begin
            r_blink <= 1'b0;
            if (r_state == ST_SET_HOUR) begin
              r_bin[HOUR_MSB:HOUR_LSB] <= w_hour_inc;
            end else if (r_state == ST_SET_MIN) begin
              r_bin[MIN_MSB:MIN_LSB] <= w_min_inc;
            end else begin
              r_bin[SEC_MSB:SEC_LSB] <= w_sec_inc;
            end
          end else if (en_1hz) begin
            r_blink <= ~r_blink;
          end
        end
        ST_COMMIT: begin
          r_state <= ST_IDLE;
          r_field <= FIELD_NONE;
          r_blink <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_field <= FIELD_NONE;
          r_blink <= 1'b0;
        end
      endcase
    end
  end

  assign bin_watch  = r_bin;
  assign set_watch  = r_set;
  assign edit_field = r_field;
  assign blink      = r_blink;

endmodule

// File: tb/tb_watch_setter.sv
// Directed bench for watch_setter: commits are scoreboarded by a monitor on set_watch,
// field/state behaviour is checked directly after each button press.
module tb_watch_setter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_1hz = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_cancel = 1'b0;
  logic [4:0]  hour = '0;
  logic [5:0]  minute = '0;
  logic [5:0]  second = '0;
  logic [16:0] bin_watch;
  logic        set_watch;
  logic [1:0]  edit_field;
  logic        blink;

  int          checks = 0;
  int          errors = 0;
  int          sw_count = 0;
  int          sw_saved;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  watch_setter #(.HOUR_MAX(23), .MINSEC_MAX(59)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_1hz    (en_1hz),
    .btn_mode  (btn_mode),
    .btn_up    (btn_up),
    .btn_cancel(btn_cancel),
    .hour      (hour),
    .minute    (minute),
    .second    (second),
    .bin_watch (bin_watch),
    .set_watch (set_watch),
    .edit_field(edit_field),
    .blink     (blink)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One-cycle press; returns at the negedge after the update is visible (edge + 2 cycles).
  task automatic press(input logic m, input logic u, input logic c);
    @(posedge clk); #2;
    btn_mode = m; btn_up = u; btn_cancel = c;
    @(posedge clk); #2;
    btn_mode = 1'b0; btn_up = 1'b0; btn_cancel = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_1hz();
    @(posedge clk); #2;
    en_1hz = 1'b1;
    @(posedge clk); #2;
    en_1hz = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [16:0] exp_v;
    fork
      forever begin
        @(negedge clk);
        if (rst && set_watch) begin
          sw_count++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL commit unexpected set_watch actual=0x%0h required=none", bin_watch);
          end else begin
            exp_v = exp_q.pop_front();
            if (bin_watch !== exp_v) begin
              errors++;
              $display("FAIL commit bin_watch actual=0x%0h required=0x%0h", bin_watch, exp_v);
            end else begin
              $display("ok   commit bin_watch = 0x%0h", bin_watch);
            end
          end
        end
      end
    join_none

    // Reset state
    step(3);
    chk("rst bin_watch", 32'(bin_watch), 32'd0);
    chk("rst set_watch", 32'(set_watch), 32'd0);
    chk("rst edit_field", 32'(edit_field), 32'd0);
    chk("rst blink", 32'(blink), 32'd0);
    rst = 1'b1;
    step(2);

    // Up/cancel in IDLE are ignored
    press(1'b0, 1'b1, 1'b0);
    chk("idle up ignored", 32'(edit_field), 32'd0);

    // 13:45:30 -> hour +2 -> commit 15:45:30
    hour = 5'd13; minute = 6'd45; second = 6'd30;
    press(1'b1, 1'b0, 1'b0);
    chk("enter SET_HOUR", 32'(edit_field), 32'd1);
    chk("load", 32'(bin_watch), 32'({5'd13, 6'd45, 6'd30}));
    press(1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    chk("hour+2", 32'(bin_watch[16:12]), 32'd15);
    press(1'b1, 1'b0, 1'b0);
    chk("enter SET_MIN", 32'(edit_field), 32'd2);
    press(1'b1, 1'b0, 1'b0);
    chk("enter SET_SEC", 32'(edit_field), 32'd3);
    exp_q.push_back({5'd15, 6'd45, 6'd30});
    press(1'b1, 1'b0, 1'b0);
    chk("COMMIT edit_field", 32'(edit_field), 32'd0);
    step(1);
    @(negedge clk);
    chk("post-commit set_watch", 32'(set_watch), 32'd0);

    // Wraps: hour 23 -> 0, second 59 -> 0, then cancel retains shadow
    hour = 5'd23; minute = 6'd10; second = 6'd59;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    chk("hour wrap", 32'(bin_watch[16:12]), 32'd0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    chk("sec wrap", 32'(bin_watch[5:0]), 32'd0);
    press(1'b0, 1'b0, 1'b1);
    chk("cancel edit_field", 32'(edit_field), 32'd0);
    chk("cancel retains", 32'(bin_watch), 32'({5'd0, 6'd10, 6'd0}));

    // Cancel from SET_MIN, then 100 quiet cycles
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    chk("SET_MIN again", 32'(edit_field), 32'd2);
    press(1'b0, 1'b0, 1'b1);
    chk("cancel SET_MIN", 32'(edit_field), 32'd0);
    sw_saved = sw_count;
    step(100);
    chk("no set_watch 100 cyc", 32'(sw_count), 32'(sw_saved));

    // Simultaneous mode+up in SET_HOUR: mode wins, hour unchanged
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    chk("mode>up edit_field", 32'(edit_field), 32'd2);
    chk("mode>up hour", 32'(bin_watch[16:12]), 32'd23);
    press(1'b1, 1'b1, 1'b1);
    chk("cancel>mode", 32'(edit_field), 32'd0);

    // Held up for 50 cycles -> single increment
    hour = 5'd5;
    press(1'b1, 1'b0, 1'b0);
    @(posedge clk); #2;
    btn_up = 1'b1;
    step(50);
    btn_up = 1'b0;
    step(2);
    @(negedge clk);
    chk("held up once", 32'(bin_watch[16:12]), 32'd6);

    // Blink toggles on en_1hz and clears on field change
    pulse_1hz();
    chk("blink on", 32'(blink), 32'd1);
    pulse_1hz();
    chk("blink off", 32'(blink), 32'd0);
    pulse_1hz();
    press(1'b1, 1'b0, 1'b0);
    chk("blink cleared", 32'(blink), 32'd0);
    press(1'b0, 1'b0, 1'b1);

    // Reset mid SET_SEC, with mode held across reset release
    hour = 5'd1; minute = 6'd2; second = 6'd3;
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    pulse_1hz();
    chk("pre-reset SET_SEC", 32'(edit_field), 32'd3);
    sw_saved = sw_count;
    #3 rst = 1'b0;
    btn_mode = 1'b1;
    #1;
    chk("async rst bin_watch", 32'(bin_watch), 32'd0);
    chk("async rst edit_field", 32'(edit_field), 32'd0);
    chk("async rst blink", 32'(blink), 32'd0);
    chk("async rst set_watch", 32'(set_watch), 32'd0);
    step(3);
    rst = 1'b1;
    step(5);
    @(negedge clk);
    chk("held btn no event", 32'(edit_field), 32'd0);
    btn_mode = 1'b0;
    step(20);
    chk("no set_watch after rst", 32'(sw_count), 32'(sw_saved));
    press(1'b1, 1'b0, 1'b0);
    chk("re-press after rst", 32'(edit_field), 32'd1);
    press(1'b0, 1'b0, 1'b1);

    // Out-of-range sampled fields clamp to 0 on first up
    hour = 5'd30; minute = 6'd63; second = 6'd7;
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    chk("hour clamp", 32'(bin_watch[16:12]), 32'd0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    chk("min clamp", 32'(bin_watch[11:6]), 32'd0);
    press(1'b1, 1'b0, 1'b0);
    exp_q.push_back({5'd0, 6'd0, 6'd7});
    press(1'b1, 1'b0, 1'b0);
    step(3);

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/watch_setter.md
WATCH_SETTER -- requirements
Module: watch_setter

Interface
REQ-001 Parameter HOUR_MAX, default 23, the largest hour value; the hour field wraps to 0 after it.
REQ-002 Parameter MINSEC_MAX, default 59, the largest minute/second value; those fields wrap to 0 after it.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 en_1hz  input  1  one-cycle strobe at 1 Hz, used only for blink.
REQ-006 btn_mode  input  1  synchronous, debounced level; rising edge advances the edit field.
REQ-007 btn_up  input  1  synchronous, debounced level; rising edge increments the field being edited.
REQ-008 btn_cancel  input  1  synchronous, debounced level; rising edge aborts setting.
REQ-009 hour  input  5  current watch hour, sampled on entry to setting.
REQ-010 minute  input  6  current watch minute, sampled on entry.
REQ-011 second  input  6  current watch second, sampled on entry.
REQ-012 bin_watch  output  17  shadow time {hour[4:0], minute[5:0], second[5:0]}.
REQ-013 set_watch  output  1  one-cycle load strobe to the watch; bin_watch is valid in the same cycle.
REQ-014 edit_field  output  2  0=none, 1=hour, 2=minute, 3=second.
REQ-015 blink  output  1  display blank enable for the field being edited.

Function
REQ-016 Button events are rising edges detected against a registered copy of each button; held levels produce no further events.
REQ-017 FSM states: IDLE, SET_HOUR, SET_MIN, SET_SEC, COMMIT.
REQ-018 In IDLE, a mode event loads hour/minute/second into the shadow register and moves to SET_HOUR.
REQ-019 Mode events move SET_HOUR to SET_MIN, SET_MIN to SET_SEC, and SET_SEC to COMMIT.
REQ-020 COMMIT lasts exactly one cycle, asserts set_watch, then returns to IDLE.
REQ-021 A cancel event in any SET_* state returns the FSM to IDLE next cycle, with no set_watch and the shadow value retained.
REQ-022 An up event in SET_HOUR increments the hour field; HOUR_MAX wraps to 0.
REQ-023 An up event in SET_MIN or SET_SEC increments that field; MINSEC_MAX wraps to 0.
REQ-024 Up and cancel events in IDLE are ignored.
REQ-025 Simultaneous events resolve with priority cancel > mode > up; only one action occurs per cycle.
REQ-026 Increments are modulo-wrapped compares, never binary overflow; out-of-range sampled inputs are clamped to 0 on the first up event.
REQ-027 edit_field is 1, 2 or 3 in SET_HOUR, SET_MIN or SET_SEC respectively, and 0 otherwise; it is registered.
REQ-028 blink toggles on each en_1hz while in a SET_* state, is forced to 0 in IDLE and COMMIT, and is cleared on every field change.
REQ-029 Latency: a button edge on cycle N produces its state or field update visible on cycle N+2 (one cycle for the edge register, one for the update).
REQ-030 bin_watch holds its value outside of up/load events.

Reset
REQ-031 Reset asserted asynchronously forces FSM=IDLE, bin_watch=0, set_watch=0, edit_field=0, blink=0, and all button edge registers=0.
REQ-032 Reset asserted mid-setting discards the edit and never emits set_watch.
REQ-033 After reset deasserts, a button already held high produces no event until it is released and pressed again.

Structure
REQ-034 A shared package holds the FSM state enum, the edit_field encodings, and the bin_watch bit-slice constants (HOUR_MSB=16, MIN_MSB=11, SEC_MSB=5).
REQ-035 One sub-module, btn_edge (a one-bit rising-edge detector), is instantiated three times.

Verification
REQ-036 Input 13:45:30; mode, up x2, mode, mode, mode -> one set_watch pulse with bin_watch={15,45,30}.
REQ-037 In SET_HOUR at 23; up -> hour becomes 0. In SET_SEC at 59; up -> second becomes 0.
REQ-038 In SET_MIN; cancel -> IDLE, edit_field=0, and no set_watch for 100 cycles.
REQ-039 mode and up rise in the same cycle while in SET_HOUR -> SET_MIN, with hour unchanged.
REQ-040 btn_up held high for 50 cycles -> exactly one increment.
REQ-041 rst pulsed low while in SET_SEC -> all outputs 0 immediately, and no set_watch after release.
